// File: rtl/fofb_xy_capture_pkg.sv
// Shared FOFB definitions: default widths and the layout of a packed {Y, X} position word.
package fofb_xy_capture_pkg;

    localparam int FOFB_ID_W = 10;
    localparam int FOFB_XY_W = 32;

    // Field index inside a packed position word; X occupies the low half.
    localparam int XY_X_FIELD = 0;
    localparam int XY_Y_FIELD = 1;

    function automatic int xy_field_lsb(input int field, input int xy_w);
        return field * xy_w;
    endfunction

endpackage

// File: rtl/fofb_xy_capture_dpram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The read data register is cleared by reset; the array itself is never initialised.
module fofb_xy_dpram #(
    parameter int AW = 11,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fofb_xy_capture.sv
// Double-buffered capture of per-BPM X/Y positions: packets fill the write bank while
// the DMA engine reads the previous frame; the banks swap on each timeframe-end edge.
module fofb_xy_capture
    import fofb_xy_capture_pkg::*;
#(
    parameter int ID_W = FOFB_ID_W,
    parameter int XY_W = FOFB_XY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              pkt_valid_i,
    input  logic [ID_W-1:0]   pkt_bpmid_i,
    input  logic [XY_W-1:0]   pkt_x_i,
    input  logic [XY_W-1:0]   pkt_y_i,
    input  logic              timeframe_end_i,
    input  logic [ID_W-1:0]   xy_buf_addr_i,
    output logic [2*XY_W-1:0] xy_buf_dat_o,
    output logic              timeframe_end_rise_o,
    output logic [ID_W:0]     pkt_count_o,
    output logic              overrun_o
);

    localparam int            DEPTH   = 2**ID_W;
    localparam logic [ID_W:0] CNT_MAX = (ID_W+1)'(DEPTH);

    logic              rd_bank_reg;
    logic              tf_cur_reg;
    logic              tf_prev_reg;
    logic              tf_armed_reg;
    logic              rise_reg;
    logic              overrun_reg;
    logic [ID_W:0]     frame_cnt_reg;
    logic [ID_W:0]     pkt_count_reg;
    logic [ID_W:0]     frame_cnt_next;
    logic              accept;
    logic              tf_edge;
    logic              cnt_full;
    logic [2*XY_W-1:0] wr_data;

    assign accept   = pkt_valid_i & enable_i;
    assign tf_edge  = tf_cur_reg & ~tf_prev_reg;
    assign cnt_full = (frame_cnt_reg == CNT_MAX);

    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        if (accept && !cnt_full) begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_pack
        assign wr_data[xy_field_lsb(gi, XY_W) +: XY_W] = (gi == XY_Y_FIELD) ? pkt_y_i : pkt_x_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_reg   <= 1'b0;
            tf_cur_reg    <= 1'b0;
            tf_prev_reg   <= 1'b0;
            tf_armed_reg  <= 1'b0;
            rise_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_cnt_reg <= '0;
            pkt_count_reg <= '0;
        end else begin
            tf_cur_reg   <= timeframe_end_i;
            // The first sample after reset seeds both stages so a level that is
            // already high is not mistaken for a fresh edge.
            tf_prev_reg  <= tf_armed_reg ? tf_cur_reg : timeframe_end_i;
            tf_armed_reg <= 1'b1;
            rise_reg     <= tf_edge;
            if (accept && cnt_full) begin
                overrun_reg <= 1'b1;
            end
            if (tf_edge) begin
                rd_bank_reg   <= ~rd_bank_reg;
                pkt_count_reg <= frame_cnt_next;
                frame_cnt_reg <= '0;
            end else begin
                frame_cnt_reg <= frame_cnt_next;
            end
        end
    end

    // Bank select is the address MSB; a write in the swap cycle still targets the old write bank.
    fofb_xy_dpram #(
        .AW(ID_W + 1),
        .DW(2 * XY_W)
    ) u_dpram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr ({~rd_bank_reg, pkt_bpmid_i}),
        .wdata (wr_data),
        .raddr ({rd_bank_reg, xy_buf_addr_i}),
        .rdata (xy_buf_dat_o)
    );

    assign timeframe_end_rise_o = rise_reg;
    assign pkt_count_o          = pkt_count_reg;
    assign overrun_o            = overrun_reg;

endmodule

// File: tb/tb_fofb_xy_capture.sv
// Self-checking bench for fofb_xy_capture: directed vector table, corner-case sequences
// and randomized traffic compared against a frame-level reference model.
module tb_fofb_xy_capture;

    localparam int ID_W  = 10;
    localparam int XY_W  = 32;
    localparam int DEPTH = 1 << ID_W;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              pkt_valid;
    logic [ID_W-1:0]   pkt_bpmid;
    logic [XY_W-1:0]   pkt_x;
    logic [XY_W-1:0]   pkt_y;
    logic              tf_end;
    logic [ID_W-1:0]   rd_addr;
    logic [2*XY_W-1:0] rd_dat;
    logic              tf_rise;
    logic [ID_W:0]     pkt_count;
    logic              overrun;

    fofb_xy_capture #(.ID_W(ID_W), .XY_W(XY_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable_i             (enable),
        .pkt_valid_i          (pkt_valid),
        .pkt_bpmid_i          (pkt_bpmid),
        .pkt_x_i              (pkt_x),
        .pkt_y_i              (pkt_y),
        .timeframe_end_i      (tf_end),
        .xy_buf_addr_i        (rd_addr),
        .xy_buf_dat_o         (rd_dat),
        .timeframe_end_rise_o (tf_rise),
        .pkt_count_o          (pkt_count),
        .overrun_o            (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: two frame buffers, the frame's packet tally and the swap bookkeeping.
    logic [63:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    int          m_rd, m_cnt;
    bit          m_pend, m_prev_tf, m_have_prev;
    bit          e_rise, e_ovr, e_dat_known;
    int          e_cnt;
    logic [63:0] e_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd = 0; m_cnt = 0; m_pend = 0; m_prev_tf = 0; m_have_prev = 0;
        e_rise = 0; e_ovr = 0; e_cnt = 0; e_dat_known = 1; e_dat = '0;
    endtask

    // Applies the rules for one clock edge given the inputs currently driven.
    task automatic model_step();
        int rb;
        rb = m_rd;
        e_dat_known = m_known[rb][rd_addr];
        e_dat       = m_mem[rb][rd_addr];
        if (pkt_valid && enable) begin
            m_mem[1-rb][pkt_bpmid]   = {pkt_y, pkt_x};
            m_known[1-rb][pkt_bpmid] = 1;
            if (m_cnt < DEPTH) m_cnt++;
            else e_ovr = 1;
        end
        e_rise = m_pend;
        if (m_pend) begin
            e_cnt = m_cnt;
            m_cnt = 0;
            m_rd  = 1 - rb;
        end
        m_pend      = m_have_prev && tf_end && !m_prev_tf;
        m_prev_tf   = tf_end;
        m_have_prev = 1;
    endtask

    task automatic check_outputs();
        chk("rise", 64'(tf_rise), 64'(e_rise));
        chk("pkt_count", 64'(pkt_count), 64'(e_cnt));
        chk("overrun", 64'(overrun), 64'(e_ovr));
        if (e_dat_known) chk("rd_data", rd_dat, e_dat);
    endtask

    task automatic cyc(input bit v, input bit en, input int id, input logic [31:0] x,
                       input logic [31:0] y, input bit tf, input int addr);
        pkt_valid = v;
        enable    = en;
        pkt_bpmid = ID_W'(id);
        pkt_x     = x;
        pkt_y     = y;
        tf_end    = tf;
        rd_addr   = ID_W'(addr);
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        $display("cyc v=%0b en=%0b id=%0d tf=%0b addr=%0d -> rise=%0b cnt=%0d ovr=%0b dat=0x%016h",
                 v, en, id, tf, addr, tf_rise, pkt_count, overrun, rd_dat);
    endtask

    // Raise timeframe_end for two cycles (the second is the edge cycle, optionally with
    // a packet), then drop it and present a read address in the cycle after the swap.
    task automatic swap(input bit v, input int id, input logic [31:0] x, input logic [31:0] y,
                        input int addr);
        cyc(0, 1, 0, 0, 0, 1, addr);
        cyc(v, 1, id, x, y, 1, addr);
        chk("swap_rise", 64'(tf_rise), 64'd1);
        cyc(0, 1, 0, 0, 0, 0, addr);
    endtask

    task automatic do_reset();
        pkt_valid = 0;
        rst = 1;
        #1;
        chk("rst_rise", 64'(tf_rise), 64'd0);
        chk("rst_count", 64'(pkt_count), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_dat", rd_dat, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    typedef struct {
        bit          v;
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        bit          tf;
        int          addr;
        bit          e_rise;
        int          e_cnt;
        bit          chk_dat;
        logic [63:0] e_dat;
    } vec_t;

    vec_t tbl [5];
    bit   tfv;

    initial begin
        rst = 0; enable = 1; pkt_valid = 0; pkt_bpmid = '0; pkt_x = '0; pkt_y = '0;
        tf_end = 0; rd_addr = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) begin
                m_known[b][i] = 0;
                m_mem[b][i]   = '0;
            end
        #2;
        do_reset();

        // Write id 5, pulse timeframe_end: rise two cycles later, then read back id 5.
        tbl[0] = '{1, 5, 32'h11, 32'h22, 0, 5, 0, 0, 0, 64'h0};
        tbl[1] = '{0, 0, 32'h0,  32'h0,  1, 5, 0, 0, 0, 64'h0};
        tbl[2] = '{0, 0, 32'h0,  32'h0,  1, 5, 1, 1, 0, 64'h0};
        tbl[3] = '{0, 0, 32'h0,  32'h0,  0, 5, 0, 1, 1, 64'h00000022_00000011};
        tbl[4] = '{0, 0, 32'h0,  32'h0,  0, 5, 0, 1, 1, 64'h00000022_00000011};
        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].v, 1, tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].tf, tbl[i].addr);
            chk("vec_rise", 64'(tf_rise), 64'(tbl[i].e_rise));
            chk("vec_count", 64'(pkt_count), 64'(tbl[i].e_cnt));
            if (tbl[i].chk_dat) chk("vec_dat", rd_dat, tbl[i].e_dat);
        end

        // Duplicate id within one frame: last write wins, both writes counted.
        cyc(1, 1, 7, 32'hA, 32'h1, 0, 0);
        cyc(1, 1, 7, 32'hB, 32'h2, 0, 0);
        swap(0, 0, 0, 0, 7);
        chk("dup_count", 64'(pkt_count), 64'd2);
        chk("dup_x", 64'(rd_dat[31:0]), 64'hB);

        // Packet in the same cycle as the edge belongs to the closing frame.
        cyc(1, 1, 9, 32'h99, 32'h98, 0, 0);
        swap(1, 3, 32'h33, 32'h44, 3);
        chk("simul_count", 64'(pkt_count), 64'd2);
        chk("simul_dat", rd_dat, 64'h00000044_00000033);

        // Overrun: one packet more than the buffer depth.
        for (int i = 0; i <= DEPTH; i++) cyc(1, 1, i % DEPTH, i, ~i, 0, 0);
        chk("ovr_pre_swap", 64'(overrun), 64'd1);
        swap(0, 0, 0, 0, 0);
        chk("ovr_count", 64'(pkt_count), 64'd1024);
        chk("ovr_flag", 64'(overrun), 64'd1);
        swap(0, 0, 0, 0, 0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        chk("ovr_empty_count", 64'(pkt_count), 64'd0);

        // Reset mid-frame with timeframe_end already high: no edge until it falls and rises.
        for (int i = 0; i < 10; i++) cyc(1, 1, 30 + i, i, i, 0, 0);
        tf_end = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, 1, 0);
            chk("rst_hold_no_rise", 64'(tf_rise), 64'd0);
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        swap(0, 0, 0, 0, 0);
        chk("rst_frame_count", 64'(pkt_count), 64'd0);

        // Disabled capture: packets ignored, the bank that comes back is untouched.
        for (int i = 0; i < 4; i++) cyc(1, 1, 20 + i, 32'h100 + i, 32'h200 + i, 0, 0);
        swap(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 20 + i, 32'h300 + i, 32'h400 + i, 0, 0);
        swap(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 20 + i, 32'hDEAD, 32'hBEEF, 0, 0);
        swap(0, 0, 0, 0, 21);
        chk("dis_count", 64'(pkt_count), 64'd0);
        chk("dis_dat", rd_dat, 64'h00000201_00000101);

        // Randomized traffic against the model.
        tfv = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) tfv = ~tfv;
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                int'($urandom_range(0, 15)), $urandom, $urandom, tfv,
                int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
